// File: rtl/trap_pkg.sv
// Shared definitions for the trapezoidal shaper (filter-chain stage 2).
// Provides the sample and difference widths, the default shaping
// parameters and the FILL/RUN state encoding used by the top level.
package trap_pkg;

    localparam int SAMPLE_W  = 32;   // stage-1 output sample width
    localparam int DIFF_W    = 34;   // exact width of the four-term delay difference

    localparam int DEF_K     = 100;  // rise length in samples
    localparam int DEF_L     = 150;  // rise + flat-top length in samples
    localparam int DEF_DEPTH = 256;  // delay-line depth, power of two
    localparam int DEF_OUT_W = 48;   // accumulator and output width

    // FILL: fewer than K+L samples of history; RUN: full history available.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } trap_state_t;

endpackage

// File: rtl/trap_delay_ram.sv
// Circular sample history for the trapezoidal shaper.
// One synchronous write port and three asynchronous read ports, so the
// taps read in the same cycle as a write return the pre-write contents.
//
// Ports:
//   clk       in   write clock
//   we        in   write enable
//   waddr     in   write address
//   wdata     in   sample to store
//   raddr_k   in   read address of the x(n-K) tap
//   raddr_l   in   read address of the x(n-L) tap
//   raddr_kl  in   read address of the x(n-K-L) tap
//   rdata_k   out  x(n-K) tap contents
//   rdata_l   out  x(n-L) tap contents
//   rdata_kl  out  x(n-K-L) tap contents
module trap_delay_ram
    import trap_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic signed [SAMPLE_W-1:0] wdata,
    input  logic [AW-1:0]              raddr_k,
    input  logic [AW-1:0]              raddr_l,
    input  logic [AW-1:0]              raddr_kl,
    output logic signed [SAMPLE_W-1:0] rdata_k,
    output logic signed [SAMPLE_W-1:0] rdata_l,
    output logic signed [SAMPLE_W-1:0] rdata_kl
);

    logic signed [SAMPLE_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; stale entries are masked by the
    // history count in the top level, so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_k  = mem[raddr_k];
    assign rdata_l  = mem[raddr_l];
    assign rdata_kl = mem[raddr_kl];

endmodule

// File: rtl/trapezoid_shaper.sv
// Trapezoidal shaper: Jordanov delay difference
//   d(n) = x(n) - x(n-K) - x(n-L) + x(n-K-L)
// followed by two cascaded accumulators p += d, s += p. The result is a
// trapezoid with rise K samples and flat top L-K samples.
// Three-stage pipeline on accepted samples: A registers d, B updates p,
// C updates s; OUT_VALID follows IN_VALID by exactly three cycles.
//
// Ports:
//   SYS_CLK    in   system clock, rising edge
//   RESET      in   synchronous active-high reset
//   IN_VALID   in   DATAIN carries a new sample this cycle
//   DATAIN     in   32-bit signed stage-1 sample
//   OUT_VALID  out  DATAOUT carries a new shaped sample
//   DATAOUT    out  OUT_W-bit signed trapezoid amplitude
//   PRIMED     out  high once K+L samples of history exist
module trapezoid_shaper
    import trap_pkg::*;
#(
    parameter int K     = DEF_K,
    parameter int L     = DEF_L,
    parameter int DEPTH = DEF_DEPTH,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                       SYS_CLK,
    input  logic                       RESET,
    input  logic                       IN_VALID,
    input  logic signed [SAMPLE_W-1:0] DATAIN,
    output logic                       OUT_VALID,
    output logic signed [OUT_W-1:0]    DATAOUT,
    output logic                       PRIMED
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] K_A  = AW'(K);
    localparam logic [AW-1:0] L_A  = AW'(L);
    localparam logic [AW-1:0] KL_A = AW'(K + L);

    trap_state_t                state;
    logic [AW-1:0]              wp;
    logic [AW-1:0]              hc;
    logic                       accept;

    logic signed [SAMPLE_W-1:0] rd_k, rd_l, rd_kl;
    logic signed [SAMPLE_W-1:0] tap_k, tap_l, tap_kl;
    logic signed [DIFF_W-1:0]   d_next;

    logic                       va, vb, vc;
    logic signed [DIFF_W-1:0]   d;
    logic signed [OUT_W-1:0]    p;
    logic signed [OUT_W-1:0]    s;

    // A sample raised together with RESET is dropped and never stored.
    assign accept = IN_VALID & ~RESET;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    trap_delay_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk      (SYS_CLK),
        .we       (accept),
        .waddr    (wp),
        .wdata    (DATAIN),
        .raddr_k  (wp - K_A),
        .raddr_l  (wp - L_A),
        .raddr_kl (wp - KL_A),
        .rdata_k  (rd_k),
        .rdata_l  (rd_l),
        .rdata_kl (rd_kl)
    );

    // Taps further back than the history collected since reset read as
    // zero, which hides whatever the RAM held before.
    always_comb begin
        tap_k  = (hc >= K_A)  ? rd_k  : '0;
        tap_l  = (hc >= L_A)  ? rd_l  : '0;
        tap_kl = (hc >= KL_A) ? rd_kl : '0;
        d_next = DIFF_W'(DATAIN) - DIFF_W'(tap_k) - DIFF_W'(tap_l) + DIFF_W'(tap_kl);
    end

    // Write pointer, saturating history count and FILL/RUN sequencing.
    // NOTE: state is updated with non-blocking assignments so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            state  <= FILL;
            wp     <= '0;
            hc     <= '0;
            PRIMED <= 1'b0;
        end else if (IN_VALID) begin
            wp <= wp + AW'(1);
            case (state)
                FILL: begin
                    hc <= hc + AW'(1);
                    if (hc == KL_A - AW'(1)) begin
                        state  <= RUN;
                        PRIMED <= 1'b1;
                    end
                end
                RUN: begin
                    // hc holds at K+L: every tap is live from here on.
                end
            endcase
        end
    end

    // Pipeline: valids travel with their data; idle cycles hold p and s.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            va <= 1'b0;
            vb <= 1'b0;
            vc <= 1'b0;
            d  <= '0;
            p  <= '0;
            s  <= '0;
        end else begin
            va <= IN_VALID;
            if (IN_VALID) begin
                d <= d_next;
            end
            vb <= va;
            if (va) begin
                p <= p + OUT_W'(d);
            end
            vc <= vb;
            if (vb) begin
                s <= s + p;
            end
        end
    end

    assign OUT_VALID = vc;
    assign DATAOUT   = s;

endmodule

// File: tb/tb_trapezoid_shaper.sv
// Bench for trapezoid_shaper. A small instance (K=4, L=6, DEPTH=16) runs
// the directed impulse/constant/gapped/mid-reset sequences against fixed
// expected tables; a default instance runs random data and widely spaced
// large impulses against an arithmetic reference model. Expected values
// and their due cycles go into per-instance queues and are popped when
// OUT_VALID appears.
module tb_trapezoid_shaper;

    localparam int SK = 4;
    localparam int SL = 6;
    localparam int SD = 16;
    localparam int DK = 100;
    localparam int DL = 150;
    localparam int DD = 256;
    localparam int W  = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Small instance
    logic                  s_reset    = 1'b1;
    logic                  s_in_valid = 1'b0;
    logic signed [31:0]    s_datain   = '0;
    logic                  s_out_valid;
    logic signed [W-1:0]   s_dataout;
    logic                  s_primed;

    // Default instance
    logic                  d_reset    = 1'b1;
    logic                  d_in_valid = 1'b0;
    logic signed [31:0]    d_datain   = '0;
    logic                  d_out_valid;
    logic signed [W-1:0]   d_dataout;
    logic                  d_primed;

    trapezoid_shaper #(.K(SK), .L(SL), .DEPTH(SD), .OUT_W(W)) dut_s (
        .SYS_CLK   (clk),
        .RESET     (s_reset),
        .IN_VALID  (s_in_valid),
        .DATAIN    (s_datain),
        .OUT_VALID (s_out_valid),
        .DATAOUT   (s_dataout),
        .PRIMED    (s_primed)
    );

    trapezoid_shaper #(.K(DK), .L(DL), .DEPTH(DD), .OUT_W(W)) dut_d (
        .SYS_CLK   (clk),
        .RESET     (d_reset),
        .IN_VALID  (d_in_valid),
        .DATAIN    (d_datain),
        .OUT_VALID (d_out_valid),
        .DATAOUT   (d_dataout),
        .PRIMED    (d_primed)
    );

    typedef struct {
        logic signed [63:0] val;
        int                 cyc;
    } exp_t;

    exp_t               sq[$];
    exp_t               dq[$];
    exp_t               s_e;
    exp_t               d_e;
    string              s_tag = "idle";
    string              d_tag = "idle";
    logic signed [63:0] d_log[$];

    // Reference model state for the default instance
    int                 hist[$];
    logic signed [W-1:0] pm = '0;
    logic signed [W-1:0] sm = '0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Output monitors: every OUT_VALID must match the oldest expectation
    // in both value and arrival cycle.
    always @(negedge clk) begin
        if (s_out_valid === 1'b1) begin
            if (sq.size() == 0) begin
                check({s_tag, "_spurious_valid"}, s_out_valid, 0);
            end else begin
                s_e = sq.pop_front();
                check({s_tag, "_dataout"}, s_dataout, s_e.val);
                check({s_tag, "_out_cycle"}, cyc, s_e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (d_out_valid === 1'b1) begin
            d_log.push_back(d_dataout);
            if (dq.size() == 0) begin
                check({d_tag, "_spurious_valid"}, d_out_valid, 0);
            end else begin
                d_e = dq.pop_front();
                check({d_tag, "_dataout"}, d_dataout, d_e.val);
                check({d_tag, "_out_cycle"}, cyc, d_e.cyc);
            end
        end
    end

    // ---------------- small-instance helpers ----------------
    task automatic step_s(input bit v, input int x, input bit push, input longint e);
        exp_t t;
        @(posedge clk); #1;
        s_in_valid = v;
        s_datain   = x;
        if (v && push) begin
            t.val = e;
            t.cyc = cyc + 3;
            sq.push_back(t);
        end
    endtask

    // One reset cycle; with_valid also raises IN_VALID, which must be dropped.
    task automatic reset_s(input bit with_valid);
        @(posedge clk); #1;
        s_reset    = 1'b1;
        s_in_valid = with_valid;
        s_datain   = 777;
        @(posedge clk); #1;
        s_reset    = 1'b0;
        s_in_valid = 1'b0;
        check({s_tag, "_rst_dataout"}, s_dataout, 0);
        check({s_tag, "_rst_out_valid"}, s_out_valid, 0);
        check({s_tag, "_rst_primed"}, s_primed, 0);
    endtask

    task automatic drain_s();
        int n = 0;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        while (sq.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check({s_tag, "_drain_left"}, sq.size(), 0);
        sq.delete();
    endtask

    // ---------------- default-instance helpers ----------------
    task automatic step_d(input bit v, input int x);
        exp_t   t;
        int     n;
        longint dd;
        @(posedge clk); #1;
        d_in_valid = v;
        d_datain   = x;
        if (v) begin
            n  = hist.size();
            dd = longint'(x);
            if (n >= DK)      dd = dd - longint'(hist[n - DK]);
            if (n >= DL)      dd = dd - longint'(hist[n - DL]);
            if (n >= DK + DL) dd = dd + longint'(hist[n - DK - DL]);
            hist.push_back(x);
            pm = pm + W'(dd);
            sm = sm + pm;
            t.val = sm;
            t.cyc = cyc + 3;
            dq.push_back(t);
        end
    endtask

    task automatic reset_d();
        @(posedge clk); #1;
        d_reset    = 1'b1;
        d_in_valid = 1'b0;
        @(posedge clk); #1;
        d_reset    = 1'b0;
        hist.delete();
        pm = '0;
        sm = '0;
        check({d_tag, "_rst_dataout"}, d_dataout, 0);
        check({d_tag, "_rst_out_valid"}, d_out_valid, 0);
        check({d_tag, "_rst_primed"}, d_primed, 0);
    endtask

    task automatic drain_d();
        int n = 0;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        while (dq.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check({d_tag, "_drain_left"}, dq.size(), 0);
        dq.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint imp10 [10] = '{1000, 2000, 3000, 4000, 4000, 4000, 3000, 2000, 1000, 0};
        longint cst10 [10] = '{5, 15, 30, 50, 70, 90, 105, 115, 120, 120};
        longint flat_exp;
        int     x;
        bit     v;

        repeat (3) @(posedge clk);

        // Reset state of both instances
        s_tag = "reset";
        reset_s(1'b0);
        d_tag = "reset";
        reset_d();

        // Impulse response
        s_tag = "impulse";
        for (int i = 0; i < 20; i++) begin
            step_s(1'b1, (i == 0) ? 1000 : 0, 1'b1, (i < 10) ? imp10[i] : 0);
        end
        drain_s();

        // Constant input from reset, with PRIMED edge after the 10th accept
        s_tag = "constant";
        reset_s(1'b0);
        for (int i = 0; i < 10; i++) begin
            step_s(1'b1, 5, 1'b1, cst10[i]);
        end
        @(negedge clk);
        check("constant_primed_before", s_primed, 0);
        step_s(1'b1, 5, 1'b1, 120);
        @(negedge clk);
        check("constant_primed_after", s_primed, 1);
        for (int i = 0; i < 8; i++) begin
            step_s(1'b1, 5, 1'b1, 120);
        end
        drain_s();

        // Gapped impulse: idle cycles carry junk data that must be ignored
        s_tag = "gapped";
        reset_s(1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                step_s(1'b1, (i == 0) ? 1000 : 0, 1'b1, (i / 2 < 10) ? imp10[i / 2] : 0);
            end else begin
                step_s(1'b0, 12345, 1'b0, 0);
            end
        end
        drain_s();

        // Mid-stream reset on the flat top; the reset cycle also carries a
        // sample that must be dropped. Samples 4 and 5 are in flight when
        // reset hits and never appear.
        s_tag = "midreset";
        reset_s(1'b0);
        for (int i = 0; i < 6; i++) begin
            step_s(1'b1, (i == 0) ? 1000 : 0, (i < 4), (i < 4) ? imp10[i] : 0);
        end
        reset_s(1'b1);
        s_tag = "post_reset_impulse";
        for (int i = 0; i < 20; i++) begin
            step_s(1'b1, (i == 0) ? 1000 : 0, 1'b1, (i < 10) ? imp10[i] : 0);
        end
        drain_s();

        // Random data across several pointer wraps (default parameters)
        d_tag = "wrap_random";
        reset_d();
        for (int i = 0; i < 1000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            x = int'($urandom_range(0, 2097152)) - 1048576;
            step_d(v, x);
        end
        drain_d();

        // Four large impulses 300 samples apart
        d_tag = "wrap_safety";
        reset_d();
        d_log.delete();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 300; j++) begin
                step_d(1'b1, (j == 0) ? 32'sd1073741824 : 0);
            end
        end
        drain_d();
        check("wrap_safety_count", d_log.size(), 1200);
        flat_exp = longint'(DK) * 64'sd1073741824;
        for (int k = 0; k < 4; k++) begin
            check("wrap_safety_flat", d_log[300 * k + 120], flat_exp);
            check("wrap_safety_zero", d_log[300 * k + 299], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
